// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - EX-stage mult/div request and HILO write-back bundle
//
// master: EX stage side, drives start/funct/operands/flush and observes the result.
// slave : hilo_muldiv side, returns stall_req/busy and the HILO write strobe and data.
//   start, funct, operand_1, operand_2, flush  : request from EX
//   stall_req, busy                            : pipeline hold and activity
//   hi_write_data, lo_write_data, hilo_write_en: HILO register stage write port
interface hilo_muldiv_if #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6
);
    logic               start;
    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  operand_1;
    logic [DATA_W-1:0]  operand_2;
    logic               flush;
    logic               stall_req;
    logic               busy;
    logic [DATA_W-1:0]  hi_write_data;
    logic [DATA_W-1:0]  lo_write_data;
    logic               hilo_write_en;

    modport master (
        output start, funct, operand_1, operand_2, flush,
        input  stall_req, busy, hi_write_data, lo_write_data, hilo_write_en
    );

    modport slave (
        input  start, funct, operand_1, operand_2, flush,
        output stall_req, busy, hi_write_data, lo_write_data, hilo_write_en
    );
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative 32-step MULT/MULTU/DIV/DIVU unit feeding HILO
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : hilo_muldiv_if.slave (request in, stall/busy and HILO write out)
module hilo_muldiv #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int STEPS   = 32
) (
    input  logic           clk,
    input  logic           rst,
    hilo_muldiv_if.slave   bus
);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'('h18);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'('h19);
    localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'('h1A);
    localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'('h1B);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic                div_q, signed_q, sign1_q, sign2_q;
    logic [DATA_W-1:0]   mcand_q;      // multiplicand magnitude, or divisor magnitude
    logic [2*DATA_W-1:0] acc_q;        // mult: {partial hi, remaining multiplier}; div: {remainder, dividend/quotient}
    logic [5:0]          cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic                valid_funct, req_div, req_signed, accept;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] mul_next, div_next, step_next, prod;
    logic [DATA_W-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
        valid_funct = (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                      (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        req_div     = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        req_signed  = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        accept      = bus.start && valid_funct && !bus.flush && (state_q == IDLE);

        abs1 = (req_signed && bus.operand_1[DATA_W-1]) ? -bus.operand_1 : bus.operand_1;
        abs2 = (req_signed && bus.operand_2[DATA_W-1]) ? -bus.operand_2 : bus.operand_2;

        // Shift-add: add multiplicand to the upper half when the current multiplier
        // LSB is set, then shift the whole accumulator right (carry enters at top).
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        // Restoring divide: bring the next dividend bit into the remainder and try
        // the subtract; a borrow (bit DATA_W) means restore and shift in a 0.
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};

        step_next = div_q ? div_next : mul_next;

        // Sign fix-up applied to the final step's result on the way into DONE.
        prod = (signed_q && (sign1_q ^ sign2_q)) ? -step_next : step_next;
        quo  = step_next[DATA_W-1:0];
        rem  = step_next[2*DATA_W-1:DATA_W];
        if (signed_q && (sign1_q ^ sign2_q)) quo = -quo;
        if (signed_q && sign1_q)             rem = -rem;

        res_hi = div_q ? rem : prod[2*DATA_W-1:DATA_W];
        res_lo = div_q ? quo : prod[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= 1'b0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        div_q    <= req_div;
                        signed_q <= req_signed;
                        sign1_q  <= req_signed & bus.operand_1[DATA_W-1];
                        sign2_q  <= req_signed & bus.operand_2[DATA_W-1];
                        mcand_q  <= req_div ? abs2 : abs1;
                        acc_q    <= {{DATA_W{1'b0}}, (req_div ? abs1 : abs2)};
                        cnt_q    <= '0;
                        if (req_div && (bus.operand_2 == '0)) begin
                            hi_q    <= bus.operand_1;
                            lo_q    <= '1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(STEPS - 1)) begin
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // stall_req is low in DONE so the instruction retires with the HILO write.
    assign bus.stall_req     = accept || ((state_q == RUN) && !bus.flush);
    assign bus.busy          = (state_q != IDLE);
    assign bus.hilo_write_en = (state_q == DONE) && !bus.flush;
    assign bus.hi_write_data = hi_q;
    assign bus.lo_write_data = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv
module tb_hilo_muldiv;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    hilo_muldiv_if #(.DATA_W(32), .FUNCT_W(6)) bus ();
    hilo_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operand values.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            F_MULT:  begin p = sa * sb; return p; end
            F_MULTU: begin up = ua * ub; return up; end
            F_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Monitor: every write strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.hilo_write_en) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got hi=%h lo=%h expected no write (cycle %0d)",
                             bus.hi_write_data, bus.lo_write_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("hi_data", 64'(bus.hi_write_data), 64'(e.hi));
                    check("lo_data", 64'(bus.lo_write_data), 64'(e.lo));
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [63:0] r;
        exp_t e;
        bus.start     = 1'b1;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        if (push) begin
            r    = model(f, a, b);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.cyc = cyc + (((f == F_DIV || f == F_DIVU) && b == 32'h0) ? 1 : 33);
            sb_q.push_back(e);
        end
        #1;
        check("accept_stall", 64'(bus.stall_req), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int stalls);
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (bus.stall_req) stalls++;
            if (!bus.busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_full(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int st;
        start_op(f, a, b, 1'b1);
        wait_idle(st);
        check("stall_cycles", 64'(st + 1),
              64'(((f == F_DIV || f == F_DIVU) && b == 32'h0) ? 1 : 33));
    endtask

    initial begin
        int st;
        logic [5:0]  f;
        logic [31:0] a, b;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        check("rst_we",    64'(bus.hilo_write_en), 64'd0);
        check("rst_hilo",  {bus.hi_write_data, bus.lo_write_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_full(F_DIVU, 32'd100, 32'd7);
        run_full(F_MULT, 32'hFFFFFFFF, 32'h2);
        run_full(F_MULTU, 32'hFFFFFFFF, 32'h2);
        run_full(F_DIV, 32'hFFFFFFF9, 32'h2);
        run_full(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_full(F_DIV, 32'd5, 32'd0);
        run_full(F_DIVU, 32'hDEADBEEF, 32'd0);

        // Flush in RUN cycle 10, then an immediate new DIVU.
        start_op(F_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_busy", 64'(bus.busy), 64'd0);
        run_full(F_DIVU, 32'd1000, 32'd33);

        // Flush during DONE suppresses the write.
        start_op(F_DIVU, 32'd50, 32'd3, 1'b0);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (bus.busy && !bus.stall_req) begin
                bus.flush = 1'b1;
                #1;
                check("done_flush_we", 64'(bus.hilo_write_en), 64'd0);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("done_flush_busy", 64'(bus.busy), 64'd0);

        // Flush in IDLE blocks acceptance.
        bus.start = 1'b1; bus.funct = F_DIVU; bus.operand_1 = 32'd9; bus.operand_2 = 32'd2;
        bus.flush = 1'b1;
        #1;
        check("idle_flush_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("idle_flush_busy", 64'(bus.busy), 64'd0);

        // Non mult/div funct is ignored.
        bus.start = 1'b1; bus.funct = 6'h10;
        #1;
        check("mfhi_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("mfhi_busy", 64'(bus.busy), 64'd0);

        // Reset at RUN cycle 20 aborts and clears outputs.
        @(negedge clk);
        start_op(F_MULT, 32'h7654321, 32'hFEDCBA98, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_stall", 64'(bus.stall_req), 64'd0);
        check("midrst_hilo", {bus.hi_write_data, bus.lo_write_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            f = F_MULT + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                default: ;
            endcase
            run_full(f, a, b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, serving MULT, MULTU, DIV and DIVU.
- Runs beside the MFHI/MFLO/MTHI/MTLO generator and feeds the HILO register stage with hi_write_data, lo_write_data and hilo_write_en.
- Holds the pipeline with stall_req while the 32-step operation runs.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- FUNCT_W, 6, funct field width.
- STEPS, 32, iteration count. Must equal DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  EX has a valid mult/div instruction this cycle.
- funct  input  FUNCT_W  MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B.
- operand_1  input  DATA_W  rs value (multiplicand or dividend).
- operand_2  input  DATA_W  rt value (multiplier or divisor).
- flush  input  1  cancel any in-flight operation (exception or redirect).
- stall_req  output  1  pipeline hold request to the stall controller.
- busy  output  1  high while not in IDLE.
- hi_write_data  output  DATA_W  product[63:32] or remainder.
- lo_write_data  output  DATA_W  product[31:0] or quotient.
- hilo_write_en  output  1  one-cycle write strobe to the HILO stage.

Behaviour:
- Reset: state=IDLE. stall_req=0, busy=0, hilo_write_en=0, hi_write_data=0, lo_write_data=0. All internal registers are cleared. Reset during RUN or DONE aborts the operation with no write.
- States: IDLE, RUN, DONE.
- Accept rule: a request is accepted only when start=1, funct is one of the four codes, flush=0 and state=IDLE.
  - On acceptance, latch funct, the signed flag (DIV/MULT) and sign bits, and latch magnitudes |op1| and |op2| (two's-complement absolute value when signed, raw when unsigned). Load the 6-bit counter with 0. Go to RUN.
  - Any other funct with start=1 is ignored: no stall, no state change.
  - start while busy is ignored. The pipeline is stalled, so EX presents the same instruction.
- stall_req is combinational and asserted:
  - in IDLE in the accept cycle;
  - in every RUN cycle.
  - It is low in DONE, so the instruction leaves EX in the same cycle as the HILO write.
- RUN, multiply: 64-bit accumulator shift-add, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial-remainder subtract.
- The counter increments each RUN cycle. After STEPS cycles (count==STEPS-1 at the edge), go to DONE.
- Divide by zero: on acceptance with a DIV/DIVU and operand_2==0, skip RUN and go straight to DONE the next cycle. Result: lo=32'hFFFFFFFF, hi=operand_1 (raw), for both signed and unsigned.
- DONE (exactly 1 cycle): hilo_write_en=1 with registered outputs valid, then return to IDLE.
- Sign fix-up in DONE (signed ops only):
  - product is negated when sign1^sign2;
  - quotient is negated when sign1^sign2;
  - remainder takes sign1.
  - 32'h80000000 / 32'hFFFFFFFF gives lo=32'h80000000, hi=0 with no trap.
- Outside DONE: hilo_write_en=0. hi_write_data and lo_write_data hold their last values (0 after reset).
- Latency: accept at edge T; RUN in cycles T+1..T+32; DONE at T+33; HILO written at the end of T+33. Divide by zero: DONE at T+1.
- Flush:
  - in RUN, return to IDLE next cycle with no write, and stall_req drops the same cycle;
  - in DONE, suppress hilo_write_en;
  - in IDLE, block acceptance.
- Simultaneous flush and rst: rst dominates. Both give the same result.

Test Plan:
- DIVU operand_1=100, operand_2=7, start for 1 cycle -> stall_req high for cycles T..T+32; at T+33 hilo_write_en=1, lo=14, hi=2. Pulse is 1 cycle wide.
- MULT 32'hFFFFFFFF * 32'h00000002 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFE. Same operands with MULTU -> hi=32'h00000001, lo=32'hFFFFFFFE.
- DIV -7/2 (32'hFFFFFFF9, 2) -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIV 5/0 -> DONE at T+1 with lo=32'hFFFFFFFF, hi=5, stall_req high only in cycle T.
- MULTU started, flush at RUN cycle 10 -> no hilo_write_en ever, busy=0 next cycle. A new DIVU accepted immediately after completes normally.
- rst asserted at RUN cycle 20 -> all outputs 0 next cycle. start with funct=6'h10 (MFHI) -> stall_req stays 0, state stays IDLE.
